// File: rtl/bus_fabric_if.sv
// Bus bundle between one master, the bus_fabric and its slave regions.
// The fabric uses the slave modport; the master/bench side uses the master modport.
interface bus_fabric_if #(
  parameter int N_SLAVES = 4,
  parameter int AW       = 16,
  parameter int DW       = 16
);
  logic                   i_m_req;
  logic [AW-1:0]          i_m_addr;
  logic [DW-1:0]          i_m_wdata;
  logic                   i_m_we;
  logic [DW-1:0]          o_m_rdata;
  logic                   o_m_ack;
  logic                   o_m_err;
  logic [N_SLAVES-1:0]    o_s_sel;
  logic [AW-1:0]          o_s_addr;
  logic [DW-1:0]          o_s_wdata;
  logic                   o_s_we;
  logic [N_SLAVES*DW-1:0] i_s_rdata;
  logic [N_SLAVES-1:0]    i_s_ack;

  modport slave (
    input  i_m_req, i_m_addr, i_m_wdata, i_m_we, i_s_rdata, i_s_ack,
    output o_m_rdata, o_m_ack, o_m_err, o_s_sel, o_s_addr, o_s_wdata, o_s_we
  );

  modport master (
    output i_m_req, i_m_addr, i_m_wdata, i_m_we, i_s_rdata, i_s_ack,
    input  o_m_rdata, o_m_ack, o_m_err, o_s_sel, o_s_addr, o_s_wdata, o_s_we
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-master address-decoding fabric with per-access timeout and a small
// error capture block (ERR_ADDR / ERR_STAT) mapped at ERR_BASE.
module bus_fabric #(
  parameter int                     N_SLAVES = 4,
  parameter int                     AW       = 16,
  parameter int                     DW       = 16,
  parameter logic [N_SLAVES*AW-1:0] SLV_BASE = {16'h0420, 16'h0410, 16'h0400, 16'h0000},
  parameter logic [N_SLAVES*AW-1:0] SLV_MASK = {16'hFFFC, 16'hFFFF, 16'hFFFE, 16'hFC00},
  parameter int                     TIMEOUT  = 15,
  parameter logic [AW-1:0]          ERR_BASE = 16'h04F0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  bus_fabric_if.slave   bus,
  output logic          o_err_int
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] ERR_STAT_ADDR = ERR_BASE + 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [N_SLAVES-1:0] sel_q, sel_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [AW-1:0]       errAddr_q, errAddr_d;
  logic [2:0]          errStat_q, errStat_d;

  logic                hit;
  logic [IW-1:0]       hitIdx;
  logic                isErrReg;
  logic                recordErr;
  logic                errType;
  logic [AW-1:0]       faultAddr;

  // Scan from the top down so the lowest matching region wins on overlap.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((bus.i_m_addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]) begin
        hit    = 1'b1;
        hitIdx = IW'(k);
      end
    end
    isErrReg = (bus.i_m_addr == ERR_BASE) || (bus.i_m_addr == ERR_STAT_ADDR);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    errAddr_d = errAddr_q;
    errStat_d = errStat_q;
    recordErr = 1'b0;
    errType   = 1'b0;
    faultAddr = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_m_req) begin
          addr_d  = bus.i_m_addr;
          wdata_d = bus.i_m_wdata;
          we_d    = bus.i_m_we;
          if (isErrReg) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            if (bus.i_m_we) begin
              if (bus.i_m_addr == ERR_STAT_ADDR) errStat_d = '0;
            end else begin
              rdata_d = (bus.i_m_addr == ERR_BASE) ? DW'(errAddr_q) : DW'(errStat_q);
            end
          end else if (hit) begin
            state_d        = S_WAIT;
            cnt_d          = '0;
            idx_d          = hitIdx;
            sel_d          = '0;
            sel_d[hitIdx]  = 1'b1;
          end else begin
            state_d   = S_RESP;
            err_d     = 1'b1;
            recordErr = 1'b1;
            faultAddr = bus.i_m_addr;
          end
        end
      end
      S_WAIT: begin
        // Ack is tested before the timeout so a coincident ack wins.
        if (|(bus.i_s_ack & sel_q)) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          sel_d   = '0;
          if (!we_q) rdata_d = bus.i_s_rdata[idx_q*DW +: DW];
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d   = S_RESP;
          err_d     = 1'b1;
          sel_d     = '0;
          recordErr = 1'b1;
          errType   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase

    if (recordErr) begin
      if (errStat_q[0]) begin
        errStat_d[2] = 1'b1;
      end else begin
        errAddr_d = faultAddr;
        errStat_d = {1'b0, errType, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      errAddr_q <= '0;
      errStat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
      errStat_q <= errStat_d;
    end
  end

  assign bus.o_m_rdata = rdata_q;
  assign bus.o_m_ack   = ack_q;
  assign bus.o_m_err   = err_q;
  assign bus.o_s_sel   = sel_q;
  assign bus.o_s_addr  = addr_q;
  assign bus.o_s_wdata = wdata_q;
  assign bus.o_s_we    = we_q;
  assign o_err_int     = errStat_q[0];

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: a vector table of master transactions
// with a scoreboard of expected completions, plus reset corner sequences.
module tb_bus_fabric;

  logic clk;
  logic reset_n;
  logic errInt;

  bus_fabric_if #(.N_SLAVES(4), .AW(16), .DW(16)) bus ();

  bus_fabric dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus),
    .o_err_int (errInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          slave;
    int          ackAfter;
    logic [15:0] ackData;
    logic        noise;
    logic        expErr;
    logic [15:0] expRdata;
    int          expWait;
    logic        expInt;
  } vec_t;

  typedef struct {
    logic        expErr;
    logic [15:0] expRdata;
    int          expWait;
    logic        expInt;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drives one request for a single cycle and queues what the master should see.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.i_m_req   = 1'b1;
    bus.i_m_addr  = v.addr;
    bus.i_m_we    = v.we;
    bus.i_m_wdata = v.wdata;
    e.expErr   = v.expErr;
    e.expRdata = v.expRdata;
    e.expWait  = v.expWait;
    e.expInt   = v.expInt;
    expQ.push_back(e);
    @(negedge clk);
    bus.i_m_req  = 1'b0;
    bus.i_m_addr = 16'h5555;
  endtask

  // Plays the slaves during WAIT, then pops the scoreboard on completion.
  task automatic checkOutput(input vec_t v);
    int          waits = 0;
    bit          done  = 0;
    logic [3:0]  expSel;
    logic [63:0] rd;
    exp_t        e;
    expSel = (v.slave >= 0) ? 4'(1 << v.slave) : 4'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.o_m_ack || bus.o_m_err) begin
        done = 1;
      end else begin
        waits++;
        check("sel", bus.o_s_sel, expSel);
        if (waits == 1) begin
          check("sAddr", bus.o_s_addr, v.addr);
          check("sWe", bus.o_s_we, v.we);
          if (v.we) check("sWdata", bus.o_s_wdata, v.wdata);
        end
        bus.i_s_ack = v.noise ? ~expSel : 4'b0;
        if (waits == v.ackAfter) bus.i_s_ack = bus.i_s_ack | expSel;
        for (int k = 0; k < 4; k++)
          rd[k*16 +: 16] = (k == v.slave) ? v.ackData : (16'hDEAD ^ 16'(k));
        bus.i_s_rdata = rd;
        @(negedge clk);
      end
    end
    bus.i_s_ack = 4'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL noResponse: got no ack/err for addr %h within 40 cycles", v.addr);
    end
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = expQ.pop_front();
    check("ack", bus.o_m_ack, !e.expErr);
    check("err", bus.o_m_err, e.expErr);
    check("rdata", bus.o_m_rdata, e.expRdata);
    check("waitCycles", waits, e.expWait);
    check("errInt", errInt, e.expInt);
    check("selInResp", bus.o_s_sel, 4'b0);
    @(negedge clk);
    check("respOneCycle", {bus.o_m_ack, bus.o_m_err}, 2'b00);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "Ack"}, bus.o_m_ack, 1'b0);
    check({tag, "Err"}, bus.o_m_err, 1'b0);
    check({tag, "Sel"}, bus.o_s_sel, 4'b0);
    check({tag, "Rdata"}, bus.o_m_rdata, 16'h0);
    check({tag, "SAddr"}, bus.o_s_addr, 16'h0);
    check({tag, "SWdata"}, bus.o_s_wdata, 16'h0);
    check({tag, "SWe"}, bus.o_s_we, 1'b0);
    check({tag, "ErrInt"}, errInt, 1'b0);
  endtask

  initial begin
    vec_t v;
    //             addr      we    wdata     slv ack ackData  nz    err   rdata    wt  int
    vecs.push_back('{16'h0123, 1'b0, 16'h0000, 0,  1, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1,  1'b0});
    vecs.push_back('{16'h0421, 1'b1, 16'h00FF, 3,  3, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 3,  1'b0});
    vecs.push_back('{16'h0400, 1'b0, 16'h0000, 1,  2, 16'h5A5A, 1'b0, 1'b0, 16'h5A5A, 2,  1'b0});
    vecs.push_back('{16'h0800, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 0,  1'b1});
    vecs.push_back('{16'h04F0, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0800, 0,  1'b1});
    vecs.push_back('{16'h04F1, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0001, 0,  1'b1});
    vecs.push_back('{16'h04F1, 1'b1, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0001, 0,  1'b0});
    vecs.push_back('{16'h04F1, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0,  1'b0});
    vecs.push_back('{16'h0410, 1'b0, 16'h0000, 2,  0, 16'h0000, 1'b0, 1'b1, 16'h0000, 15, 1'b1});
    vecs.push_back('{16'h04F1, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0003, 0,  1'b1});
    vecs.push_back('{16'h0900, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b1, 16'h0003, 0,  1'b1});
    vecs.push_back('{16'h04F1, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0007, 0,  1'b1});
    vecs.push_back('{16'h04F0, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0410, 0,  1'b1});
    vecs.push_back('{16'h04F0, 1'b1, 16'hFFFF, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0410, 0,  1'b1});
    vecs.push_back('{16'h04F0, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0410, 0,  1'b1});
    vecs.push_back('{16'h04F1, 1'b1, 16'hABCD, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0410, 0,  1'b0});
    vecs.push_back('{16'h0410, 1'b0, 16'h0000, 2, 15, 16'hC0DE, 1'b0, 1'b0, 16'hC0DE, 15, 1'b0});
    vecs.push_back('{16'h04F1, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0,  1'b0});
    vecs.push_back('{16'h03FF, 1'b0, 16'h0000, 0,  1, 16'h1111, 1'b0, 1'b0, 16'h1111, 1,  1'b0});
    vecs.push_back('{16'h0401, 1'b0, 16'h0000, 1,  1, 16'h2222, 1'b0, 1'b0, 16'h2222, 1,  1'b0});
    vecs.push_back('{16'h0410, 1'b0, 16'h0000, 2,  4, 16'h3333, 1'b1, 1'b0, 16'h3333, 4,  1'b0});
    vecs.push_back('{16'h0402, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b1, 16'h3333, 0,  1'b1});
    vecs.push_back('{16'h04F0, 1'b0, 16'h0000, -1, 0, 16'h0000, 1'b0, 1'b0, 16'h0402, 0,  1'b1});

    reset_n       = 1'b0;
    bus.i_m_req   = 1'b0;
    bus.i_m_addr  = 16'h0;
    bus.i_m_wdata = 16'h0;
    bus.i_m_we    = 1'b0;
    bus.i_s_ack   = 4'b0;
    bus.i_s_rdata = 64'h0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Reset dropped in the middle of a slave access.
    @(negedge clk);
    bus.i_m_req  = 1'b1;
    bus.i_m_addr = 16'h0123;
    bus.i_m_we   = 1'b0;
    @(negedge clk);
    bus.i_m_req = 1'b0;
    @(negedge clk);
    check("preResetSel", bus.o_s_sel, 4'b0001);
    #2 reset_n = 1'b0;
    #1 checkResetValues("midWait");
    @(negedge clk);
    check("heldResetSel", bus.o_s_sel, 4'b0000);
    reset_n = 1'b1;

    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);
    v = vecs[17];
    applyStimulus(v);
    checkOutput(v);

    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboardLeftover: got %0d entries expected 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of slave regions (1..16).
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have parameter SLV_BASE, default {16'h0420,16'h0410,16'h0400,16'h0000}: packed N_SLAVES*AW region bases, slave 0 in LSBs.
REQ-005 SHALL have parameter SLV_MASK, default {16'hFFFC,16'hFFFF,16'hFFFE,16'hFC00}: packed N_SLAVES*AW region masks.
REQ-006 SHALL have parameter TIMEOUT, default 15: WAIT cycles before bus error; 0 disables timeout.
REQ-007 SHALL have parameter ERR_BASE, default 16'h04F0: ERR_ADDR at ERR_BASE, ERR_STAT at ERR_BASE+1.
REQ-008 i_clk  input  1  clock; all state changes on rising edge.
REQ-009 i_reset_n  input  1  asynchronous active-low reset.
REQ-010 i_m_req  input  1  master request strobe.
REQ-011 i_m_addr  input  AW  master address.
REQ-012 i_m_wdata  input  DW  master write data.
REQ-013 i_m_we  input  1  master write enable (1 write, 0 read).
REQ-014 o_m_rdata  output  DW  read data, valid while o_m_ack.
REQ-015 o_m_ack  output  1  one-cycle successful completion.
REQ-016 o_m_err  output  1  one-cycle error completion.
REQ-017 o_s_sel  output  N_SLAVES  one-hot slave select.
REQ-018 o_s_addr / o_s_wdata / o_s_we  output  AW / DW / 1  registered copies of the accepted request.
REQ-019 i_s_rdata  input  N_SLAVES*DW  packed slave read data.
REQ-020 i_s_ack  input  N_SLAVES  per-slave completion strobe.
REQ-021 o_err_int  output  1  level interrupt, equals ERR_STAT[0].

Function
REQ-022 SHALL implement FSM with states IDLE, WAIT, RESP.
REQ-023 IDLE: on edge with i_m_req=1, SHALL latch addr/wdata/we and decode; i_m_req is ignored in WAIT and RESP.
REQ-024 Decode SHALL hit slave k when (addr & mask_k)==base_k; overlapping hits resolve to the lowest k.
REQ-025 Addresses ERR_BASE and ERR_BASE+1 SHALL take priority over all slaves and complete internally: IDLE->RESP with o_m_ack; no o_s_sel.
REQ-026 A slave hit SHALL go IDLE->WAIT with o_s_sel[k]=1 for every WAIT cycle.
REQ-027 A decode miss SHALL go IDLE->RESP with o_m_err and record error type 0 (decode).
REQ-028 WAIT: i_s_ack[k] of the selected slave SHALL latch i_s_rdata slice k into o_m_rdata and go to RESP with o_m_ack; acks from unselected slaves are ignored.
REQ-029 WAIT: counter SHALL count WAIT cycles; when it reaches TIMEOUT without ack, SHALL go to RESP with o_m_err, record error type 1 (timeout), and drop o_s_sel.
REQ-030 If ack and timeout occur on the same edge, ack SHALL win.
REQ-031 RESP SHALL last exactly one cycle, then IDLE; minimum slave-access latency is 2 edges (request edge to ack cycle).
REQ-032 Errors SHALL set ERR_ADDR=faulting address, ERR_STAT[0]=1 (valid), ERR_STAT[1]=type; if ERR_STAT[0] already 1, SHALL set ERR_STAT[2] (overflow) and keep the first ERR_ADDR.
REQ-033 A write of any value to ERR_STAT SHALL clear ERR_STAT[2:0]; ERR_ADDR is read-only; upper ERR_STAT bits read 0.
REQ-034 o_m_rdata SHALL hold its last value outside RESP; writes return o_m_rdata unchanged.

Reset
REQ-035 While i_reset_n=0, SHALL asynchronously force IDLE, counter 0, ERR_ADDR 0, ERR_STAT 0, o_m_rdata 0, o_m_ack 0, o_m_err 0, o_s_sel 0, o_s_addr 0, o_s_wdata 0, o_s_we 0, o_err_int 0.
REQ-036 Reset mid-WAIT SHALL abandon the transaction with no ack/err and no error recorded.

Verification
REQ-037 Read 0x0123, slave 0 acks first WAIT cycle with 0xBEEF -> o_s_sel=0001 one cycle, o_m_ack with o_m_rdata=0xBEEF on the next cycle.
REQ-038 Write 0x0421 data 0x00FF, slave 3 acks after 3 WAIT cycles -> o_s_sel=1000 for 3 cycles, o_s_we=1, o_s_wdata=0x00FF, then o_m_ack.
REQ-039 Read 0x0800 -> o_m_err next cycle, no o_s_sel; ERR_ADDR=0x0800, ERR_STAT=0x1, o_err_int=1.
REQ-040 Read 0x0410, slave 2 never acks -> o_m_err after 15 WAIT cycles, ERR_STAT=0x3; then read 0x0900 -> ERR_STAT=0x7, ERR_ADDR stays 0x0410.
REQ-041 Write 0x04F1 -> o_m_ack, ERR_STAT=0, o_err_int=0; ack and timeout on the same edge -> o_m_ack, no error.
REQ-042 Drop i_reset_n during WAIT -> outputs and state immediately at reset values; first request after release behaves as REQ-037.
